// File: rtl/vga_vram_line_prefetch.sv
// rtl/vga_vram_line_prefetch.sv - framebuffer read master with pixel FIFO and EOL/EOF stream markers
// Optional underflow statistics counter enabled by VGA_LINE_PREFETCH_UNDERFLOW_STAT_EN.
module vga_vram_line_prefetch #(
    parameter int H_PIXELS   = 640,
    parameter int V_LINES    = 480,
    parameter int FIFO_DEPTH = 32
) (
    input  logic        iCLOCK,
    input  logic        iRESET_SYNC,
    input  logic        iFRAME_START,
    input  logic [19:0] iBASE_ADDR,
    output logic        oREAD_ENABLE,
    output logic        oREAD_REQ,
    output logic [19:0] oREAD_ADDR,
    input  logic        iREAD_BUSY,
    input  logic        iREAD_VALID,
    input  logic [15:0] iREAD_DATA,
    output logic        oPIXEL_VALID,
    output logic [15:0] oPIXEL_DATA,
    output logic        oPIXEL_EOL,
    output logic        oPIXEL_EOF,
    input  logic        iPIXEL_READY,
    output logic        oBUSY,
    output logic        oOVERFLOW_ERR,
    output logic [15:0] oUNDERFLOW_COUNT
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int X_W   = $clog2(H_PIXELS + 1);
    localparam int Y_W   = $clog2(V_LINES + 1);
    localparam logic [CNT_W:0]   DEPTH_SUM = (CNT_W + 1)'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);
    localparam logic [19:0]      LAST_IDX  = 20'(H_PIXELS * V_LINES - 1);
    localparam logic [X_W-1:0]   X_LAST    = X_W'(H_PIXELS - 1);
    localparam logic [Y_W-1:0]   Y_LAST    = Y_W'(V_LINES - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2,
        ST_FLUSH = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [19:0]      base_q;
    logic [19:0]      issue_idx_q;
    logic [CNT_W-1:0] inflight_q;
    logic [CNT_W-1:0] fifo_cnt_q;
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [15:0]      mem_q [FIFO_DEPTH];
    logic [X_W-1:0]   x_q;
    logic [Y_W-1:0]   y_q;
    logic             ovf_q;

    logic credit;
    logic issue_req;
    logic issue_fire;
    logic abort;
    logic frame_init;
    logic flush_exit;
    logic accept_ret;
    logic fifo_full;
    logic push;
    logic pop;
    logic ret_dec;
    logic fifo_clear;

    // Credit counts both buffered pixels and reads still owed by memory.
    assign credit     = ({1'b0, fifo_cnt_q} + {1'b0, inflight_q}) < DEPTH_SUM;
    assign issue_fire = issue_req && !iREAD_BUSY;
    assign abort      = iFRAME_START && (state_q == ST_FETCH || state_q == ST_DRAIN);
    assign frame_init = iFRAME_START && (state_q == ST_IDLE);
    assign flush_exit = (state_q == ST_FLUSH) && (inflight_q == '0);
    assign fifo_full  = (fifo_cnt_q == DEPTH_CNT);
    assign accept_ret = iREAD_VALID && !iFRAME_START &&
                        (state_q == ST_FETCH || state_q == ST_DRAIN);
    assign push       = accept_ret && !fifo_full;
    assign pop        = oPIXEL_VALID && iPIXEL_READY;
    assign ret_dec    = iREAD_VALID && (inflight_q != '0);
    assign fifo_clear = frame_init || abort;

    always_ff @(posedge iCLOCK) begin
        if (iRESET_SYNC) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        issue_req = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (iFRAME_START) state_d = ST_FETCH;
            end
            ST_FETCH: begin
                issue_req = credit && !iFRAME_START;
                if (iFRAME_START) begin
                    state_d = ST_FLUSH;
                end else if (issue_req && !iREAD_BUSY && issue_idx_q == LAST_IDX) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (iFRAME_START) begin
                    state_d = ST_FLUSH;
                end else if (inflight_q == '0 && fifo_cnt_q == '0) begin
                    state_d = ST_IDLE;
                end
            end
            ST_FLUSH: begin
                if (inflight_q == '0) state_d = ST_FETCH;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge iCLOCK) begin
        if (iRESET_SYNC) begin
            base_q <= '0;
        end else if (iFRAME_START) begin
            base_q <= iBASE_ADDR;
        end
    end

    always_ff @(posedge iCLOCK) begin
        if (iRESET_SYNC || frame_init || flush_exit) begin
            issue_idx_q <= '0;
        end else if (issue_fire) begin
            issue_idx_q <= issue_idx_q + 20'd1;
        end
    end

    // Late returns of an aborted frame still decrement, so FLUSH can tell when memory is quiet.
    always_ff @(posedge iCLOCK) begin
        if (iRESET_SYNC) begin
            inflight_q <= '0;
        end else if (issue_fire && !ret_dec) begin
            inflight_q <= inflight_q + CNT_W'(1);
        end else if (!issue_fire && ret_dec) begin
            inflight_q <= inflight_q - CNT_W'(1);
        end
    end

    always_ff @(posedge iCLOCK) begin
        if (iRESET_SYNC) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (fifo_clear) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= iREAD_DATA;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            if (push && !pop) begin
                fifo_cnt_q <= fifo_cnt_q + CNT_W'(1);
            end else if (pop && !push) begin
                fifo_cnt_q <= fifo_cnt_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge iCLOCK) begin
        if (iRESET_SYNC || frame_init || flush_exit) begin
            x_q <= '0;
            y_q <= '0;
        end else if (pop) begin
            if (x_q == X_LAST) begin
                x_q <= '0;
                y_q <= (y_q == Y_LAST) ? '0 : y_q + Y_W'(1);
            end else begin
                x_q <= x_q + X_W'(1);
            end
        end
    end

    always_ff @(posedge iCLOCK) begin
        if (iRESET_SYNC) begin
            ovf_q <= 1'b0;
        end else if (accept_ret && fifo_full) begin
            ovf_q <= 1'b1;
        end
    end

`ifdef VGA_LINE_PREFETCH_UNDERFLOW_STAT_EN
    logic [15:0] underflow_q;

    always_ff @(posedge iCLOCK) begin
        if (iRESET_SYNC || iFRAME_START) begin
            underflow_q <= '0;
        end else if (state_q == ST_FETCH && iPIXEL_READY && fifo_cnt_q == '0 &&
                     underflow_q != 16'hFFFF) begin
            underflow_q <= underflow_q + 16'd1;
        end
    end

    assign oUNDERFLOW_COUNT = underflow_q;
`else
    assign oUNDERFLOW_COUNT = 16'h0;
`endif

    assign oREAD_ENABLE  = issue_req;
    assign oREAD_REQ     = issue_req;
    assign oREAD_ADDR    = base_q + issue_idx_q;
    assign oPIXEL_VALID  = (fifo_cnt_q != '0) && (state_q != ST_FLUSH);
    assign oPIXEL_DATA   = mem_q[rd_ptr_q];
    assign oPIXEL_EOL    = (x_q == X_LAST);
    assign oPIXEL_EOF    = (x_q == X_LAST) && (y_q == Y_LAST);
    assign oBUSY         = (state_q != ST_IDLE);
    assign oOVERFLOW_ERR = ovf_q;

endmodule
